// File: rtl/llm_pkg.sv
// Shared FP16 constants and types for the int8 outlier-detection datapath.
package llm_pkg;

    typedef logic [15:0] fp16_t;

    localparam logic [14:0] FP16_MAG_MASK         = 15'h7FFF;
    localparam logic [4:0]  FP16_EXP_ALL_ONES     = 5'h1F;
    localparam fp16_t       OUTLIER_THRES_DEFAULT = 16'h4F80;

endpackage

// File: rtl/fp16_mag_gt.sv
// Single-element FP16 magnitude compare: result = |x| > |THRES| on raw bit patterns.
// Inf/NaN encodings sit above every finite magnitude, so they compare as hits.
module fp16_mag_gt
    import llm_pkg::*;
#(
    parameter fp16_t THRES = OUTLIER_THRES_DEFAULT
) (
    input  fp16_t x,
    output logic  result
);

    localparam logic [15:0] THRES_MAG = {1'b0, THRES[14:0] & FP16_MAG_MASK};

    logic [15:0] x_mag;

    assign x_mag  = x & {1'b0, FP16_MAG_MASK};
    assign result = (x_mag > THRES_MAG);

endmodule

// File: rtl/outlier_col_mask.sv
// Streaming per-column outlier detector: ORs |x| > THRES over all rows and beats of a
// tile, then presents the column mask and its popcount with a valid/ready handshake.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_ACC  | no result pending; beats accumulate freely
//  ST_HOLD | result presented on data_out; input stalls until it is taken
module outlier_col_mask
    import llm_pkg::*;
#(
    parameter int    IN_WIDTH       = 16,
    parameter int    IN_SIZE        = 4,
    parameter int    IN_PARALLELISM = 1,
    parameter int    IN_DEPTH       = 4,
    parameter fp16_t THRES          = OUTLIER_THRES_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [IN_WIDTH-1:0]            data_in [IN_SIZE*IN_PARALLELISM],
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
    output logic [IN_SIZE-1:0]             data_out,
    output logic [$clog2(IN_SIZE+1)-1:0]   data_out_count,
    output logic                           data_out_valid,
    input  logic                           data_out_ready
);

    localparam int NUM_ELEM = IN_SIZE * IN_PARALLELISM;
    localparam int CNT_W    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int POP_W    = $clog2(IN_SIZE + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]         state;
    logic [IN_SIZE-1:0] acc;
    logic [CNT_W-1:0]   beat_cnt;
    logic [IN_SIZE-1:0] out_mask;
    logic [POP_W-1:0]   out_cnt;

    logic [NUM_ELEM-1:0] elem_hit;
    logic [IN_SIZE-1:0]  beat_hit;
    logic [IN_SIZE-1:0]  merged;
    logic [POP_W-1:0]    merged_cnt;
    logic                out_valid;
    logic                beat_accept;
    logic                last_accept;

    for (genvar i = 0; i < NUM_ELEM; i++) begin : g_cmp
        fp16_mag_gt #(
            .THRES (THRES)
        ) u_cmp (
            .x      (data_in[i]),
            .result (elem_hit[i])
        );
    end

    // Every row contributes; no single row is taken as representative of the column.
    always_comb begin
        beat_hit = '0;
        for (int r = 0; r < IN_PARALLELISM; r++) begin
            for (int c = 0; c < IN_SIZE; c++) begin
                beat_hit[c] = beat_hit[c] | elem_hit[r*IN_SIZE + c];
            end
        end
    end

    assign merged = acc | beat_hit;

    always_comb begin
        merged_cnt = '0;
        for (int c = 0; c < IN_SIZE; c++) begin
            merged_cnt = merged_cnt + POP_W'(merged[c]);
        end
    end

    assign out_valid = (state == ST_HOLD);

    // Combinational from data_out_ready so a held result and a new beat can trade in one cycle.
    assign data_in_ready = rst && (!out_valid || data_out_ready);
    assign beat_accept   = data_in_valid && data_in_ready;
    assign last_accept   = beat_accept && (beat_cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_ACC;
            acc      <= '0;
            beat_cnt <= '0;
            out_mask <= '0;
            out_cnt  <= '0;
        end else begin
            if (beat_accept) begin
                if (beat_cnt == LAST_BEAT) begin
                    out_mask <= merged;
                    out_cnt  <= merged_cnt;
                    acc      <= '0;
                    beat_cnt <= '0;
                end else begin
                    acc      <= merged;
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end

            if (last_accept) begin
                state <= ST_HOLD;
            end else if (out_valid && data_out_ready) begin
                state <= ST_ACC;
            end
        end
    end

    assign data_out       = out_mask;
    assign data_out_count = out_cnt;
    assign data_out_valid = out_valid;

endmodule

// File: tb/tb_outlier_col_mask.sv
// Bench for outlier_col_mask: value-domain FP16 reference model, per-cycle compare,
// tile scoreboard, directed boundary tests and randomized valid/ready streaming.
module tb_outlier_col_mask;

    localparam int SZ    = 4;
    localparam int PAR   = 2;
    localparam int DEPTH = 3;
    localparam int NEL   = SZ * PAR;
    localparam int PW    = $clog2(SZ + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       data_in [NEL];
    logic              data_in_valid;
    logic              data_in_ready;
    logic [SZ-1:0]     data_out;
    logic [PW-1:0]     data_out_count;
    logic              data_out_valid;
    logic              data_out_ready;

    outlier_col_mask #(
        .IN_WIDTH       (16),
        .IN_SIZE        (SZ),
        .IN_PARALLELISM (PAR),
        .IN_DEPTH       (DEPTH),
        .THRES          (16'h4F80)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_count (data_out_count),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // |x| > 30.0 evaluated on the decoded value, in units of 2^-24.
    function automatic bit is_outlier(input logic [15:0] x);
        int     e;
        longint m;
        e = int'(x[14:10]);
        if (e == 31) return 1'b1;
        if (e == 0) m = longint'(x[9:0]);
        else        m = longint'(1024 + int'(x[9:0])) << (e - 1);
        return m > 64'd503316480;
    endfunction

    // Behavioural model, updated at each rising edge from the inputs seen there.
    bit            m_valid = 0;
    bit [SZ-1:0]   m_mask  = '0;
    int            m_cnt   = 0;
    bit [SZ-1:0]   m_part  = '0;
    int            m_beats = 0;
    bit            m_acc_evt = 0;
    int            tiles_made = 0;
    int            tiles_seen = 0;
    bit [SZ-1:0]   exp_q [$];

    always @(posedge clk) begin
        bit exp_ready;
        bit drained;
        bit tile_evt;
        m_acc_evt = 0;
        tile_evt  = 0;
        if (!rst) begin
            m_valid = 0; m_mask = '0; m_cnt = 0; m_part = '0; m_beats = 0;
            tiles_made = tiles_made - exp_q.size();
            exp_q.delete();
        end else begin
            exp_ready = !m_valid || data_out_ready;
            drained   = m_valid && data_out_ready;
            if (data_in_valid && exp_ready) begin
                m_acc_evt = 1;
                for (int i = 0; i < NEL; i++)
                    if (is_outlier(data_in[i])) m_part[i % SZ] = 1'b1;
                m_beats++;
                if (m_beats == DEPTH) begin
                    m_mask  = m_part;
                    m_cnt   = $countones(m_part);
                    m_part  = '0;
                    m_beats = 0;
                    m_valid = 1;
                    tile_evt = 1;
                    exp_q.push_back(m_mask);
                    tiles_made++;
                end
            end
            if (drained && !tile_evt) m_valid = 0;
        end
    end

    // Compare process: outputs and ready against the model every cycle, plus scoreboard.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", int'(data_in_ready), int'(rst && (!m_valid || data_out_ready)));
            chk("out_valid", int'(data_out_valid), int'(m_valid));
            chk("out_mask", int'(data_out), int'(m_mask));
            chk("out_count", int'(data_out_count), m_cnt);
            if (rst && data_out_valid && data_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_tile", 1, 0);
                end else begin
                    chk("sb_mask", int'(data_out), int'(exp_q[0]));
                    chk("sb_count", int'(data_out_count), $countones(exp_q[0]));
                    void'(exp_q.pop_front());
                    tiles_seen++;
                end
            end
        end
    end

    logic [15:0] beat [NEL];

    task automatic fill_beat(input logic [15:0] v);
        for (int i = 0; i < NEL; i++) beat[i] = v;
    endtask

    task automatic send_beat(output int waited);
        data_in       = beat;
        data_in_valid = 1'b1;
        waited        = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!m_acc_evt && waited < 50);
        if (!m_acc_evt) chk("beat_accept_timeout", 0, 1);
        data_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        data_in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic expect_tile(input string nm, input int mask, input int cnt);
        chk({nm, "_valid"}, int'(data_out_valid), 1);
        chk({nm, "_mask"}, int'(data_out), mask);
        chk({nm, "_count"}, int'(data_out_count), cnt);
        chk({nm, "_model_mask"}, int'(m_mask), mask);
    endtask

    initial begin
        int w;
        int cyc;
        int target;
        logic [15:0] v;
        logic [15:0] specials [5];

        specials[0] = 16'h4F80; specials[1] = 16'h4F81; specials[2] = 16'h7C00;
        specials[3] = 16'hFC00; specials[4] = 16'h7E00;

        rst = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b0;
        fill_beat(16'h0000);
        data_in = beat;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        chk("rst_mask", int'(data_out), 0);
        chk("rst_count", int'(data_out_count), 0);
        chk("rst_valid", int'(data_out_valid), 0);
        chk("rst_ready", int'(data_in_ready), 0);
        rst = 1'b1;
        data_out_ready = 1'b1;
        idle(1);

        // 1: reset mid-tile discards the partial column-2 hits
        fill_beat(16'h3C00); beat[2] = 16'h5000;
        send_beat(w); send_beat(w);
        rst = 1'b0;
        #1 chk("t1_ready_in_reset", int'(data_in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        fill_beat(16'h3C00);
        send_beat(w); send_beat(w);
        chk("t1_no_early_tile", int'(data_out_valid), 0);
        send_beat(w);
        expect_tile("t1", 4'b0000, 0);
        idle(2);

        // 2: only row 1 / column 3 of beat 2 is an outlier
        fill_beat(16'h3C00);
        send_beat(w); send_beat(w);
        chk("t2_not_yet_valid", int'(data_out_valid), 0);
        beat[1*4+3] = 16'hD000;
        send_beat(w);
        expect_tile("t2", 4'b1000, 1);
        idle(2);

        // 3: equal-to-threshold, just-above, Inf, NaN, signed zero and subnormals
        fill_beat(16'h0000);
        beat[0] = 16'h4F80; beat[1] = 16'h4F81; beat[2] = 16'h7C00; beat[3] = 16'h7E00;
        beat[4] = 16'h8000; beat[5] = 16'h03FF; beat[7] = 16'h0001;
        send_beat(w);
        fill_beat(16'h0000); beat[0] = 16'hCF80;
        send_beat(w);
        fill_beat(16'h3C00); beat[4] = 16'h4F80;
        send_beat(w);
        expect_tile("t3", 4'b1110, 3);
        idle(2);

        // 4: backpressure holds the result and stalls the pending beat
        fill_beat(16'h3C00); beat[0] = 16'hD400;
        send_beat(w);
        fill_beat(16'h3C00); beat[6] = 16'h5000;
        send_beat(w);
        fill_beat(16'h3C00);
        send_beat(w);
        data_out_ready = 1'b0;
        expect_tile("t4", 4'b0101, 2);
        fill_beat(16'h3C00); beat[3] = 16'hD000;
        data_in = beat; data_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_stall_ready", int'(data_in_ready), 0);
            expect_tile("t4_hold", 4'b0101, 2);
        end
        data_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_drop", int'(data_out_valid), 0);
        chk("t4_beat_taken", int'(m_acc_evt), 1);
        data_in_valid = 1'b0;
        fill_beat(16'h3C00);
        send_beat(w); send_beat(w);
        expect_tile("t4_next", 4'b1000, 1);
        idle(2);

        // 5: four back-to-back tiles, one beat per cycle
        begin
            int masks [4];
            masks[0] = 4'b0001; masks[1] = 4'b0010; masks[2] = 4'b1111; masks[3] = 4'b0000;
            for (int t = 0; t < 4; t++) begin
                for (int k = 0; k < DEPTH; k++) begin
                    fill_beat(16'h3C00);
                    for (int c = 0; c < SZ; c++)
                        if (masks[t][c] && (c % DEPTH) == k) beat[(c % 2)*SZ + c] = 16'h7C00;
                    send_beat(w);
                    chk("t5_one_cycle_per_beat", w, 1);
                end
                expect_tile("t5", masks[t], $countones(masks[t][3:0]));
            end
        end
        idle(2);

        // 6: random valid/ready over 1000 tiles
        target = tiles_made + 1000;
        cyc = 0;
        while (tiles_made < target && cyc < 60000) begin
            data_in_valid  = ($urandom_range(0, 9) < 7);
            data_out_ready = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < NEL; i++) begin
                case ($urandom_range(0, 19))
                    0:       v = 16'($urandom());
                    1:       v = specials[$urandom_range(0, 4)];
                    default: v = {1'($urandom()), 15'($urandom_range(0, 16'h4F00))};
                endcase
                data_in[i] = v;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6_tile_budget", int'(tiles_made >= target), 1);
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        idle(4);
        chk("sb_drained", exp_q.size(), 0);
        chk("sb_balance", tiles_seen, tiles_made);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
